rf_writeback_ctrl: RTL and testbench

- Write-side controller for the 32x32 register file.
- Collects writeback results from two producers: the single-cycle ALU path and the multi-cycle load/MUL unit. Each producer uses a valid/ready handshake.
- Arbitrates between them and buffers accepted results in a small FIFO. Drives the register file write port (RD, write enable, write data) from registered outputs.
- Keeps a 32-bit busy scoreboard that the issue stage uses for RAW-hazard stalls.

---
 rtl/rf_wb_if.sv | 43 ++++
 rtl/rf_writeback_ctrl.sv | 110 +++++++++++
 tb/tb_rf_writeback_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_if.sv
// Writeback-side bundle: issue-stage reservations, ALU and load/MUL producer handshakes,
// register-file write port and scoreboard/occupancy status.
interface rf_wb_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  localparam int PW = $clog2(DEPTH) + 1;

  logic            rsv_valid;
  logic [4:0]      rsv_rd;

  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;

  logic            mem_valid;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            mem_ready;

  logic            rf_wr_en;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic [31:0]     busy;
  logic [PW-1:0]   pending;

  modport master (
    output rsv_valid, rsv_rd,
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready,
    input  rf_wr_en, rf_rd, rf_wdata, busy, pending
  );

  modport slave (
    input  rsv_valid, rsv_rd,
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready,
    output rf_wr_en, rf_rd, rf_wdata, busy, pending
  );
endinterface

// File: rtl/rf_writeback_ctrl.sv
// Register-file write controller: round-robin arbitration of ALU and load/MUL results into a
// small FIFO drained one write per cycle, plus a busy scoreboard for RAW-hazard stalls.
module rf_writeback_ctrl #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  rf_wb_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

  typedef enum logic {RR_ALU = 1'b0, RR_MEM = 1'b1} rr_e;

  rr_e             rr_q, rr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   pend_q, pend_d;
  logic [4:0]      ent_rd_q  [DEPTH];
  logic [XLEN-1:0] ent_dat_q [DEPTH];

  logic            rf_wr_en_q, rf_wr_en_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic [31:0]     busy_q, busy_d;

  logic            full, alu_rdy, mem_rdy, alu_acc, mem_acc, push, pop;
  logic [4:0]      acc_rd;
  logic [XLEN-1:0] acc_dat;

  // Ready looks only at the competitor's valid so a producer never sees its own valid looped back.
  assign full    = (pend_q == FULL_CNT);
  assign alu_rdy = !full && (!bus.mem_valid || rr_q == RR_ALU);
  assign mem_rdy = !full && (!bus.alu_valid || rr_q == RR_MEM);
  assign alu_acc = bus.alu_valid && alu_rdy;
  assign mem_acc = bus.mem_valid && mem_rdy;

  always_comb begin
    acc_rd     = alu_acc ? bus.alu_rd : bus.mem_rd;
    acc_dat    = alu_acc ? bus.alu_data : bus.mem_data;
    push       = (alu_acc || mem_acc) && (acc_rd != 5'd0);
    pop        = (pend_q != '0);

    rr_d = rr_q;
    if (bus.alu_valid && bus.mem_valid) begin
      if (alu_acc)      rr_d = RR_MEM;
      else if (mem_acc) rr_d = RR_ALU;
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    case ({push, pop})
      2'b10:   pend_d = pend_q + PW'(1);
      2'b01:   pend_d = pend_q - PW'(1);
      default: pend_d = pend_q;
    endcase

    rf_wr_en_d = pop;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    busy_d     = busy_q;
    if (pop) begin
      rf_rd_d    = ent_rd_q[rd_ptr_q];
      rf_wdata_d = ent_dat_q[rd_ptr_q];
      busy_d[ent_rd_q[rd_ptr_q]] = 1'b0;
    end
    // A fresh reservation beats the retiring write to the same register.
    if (bus.rsv_valid && bus.rsv_rd != 5'd0) busy_d[bus.rsv_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd_q[wr_ptr_q]  <= acc_rd;
      ent_dat_q[wr_ptr_q] <= acc_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= RR_ALU;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pend_q     <= '0;
      rf_wr_en_q <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      rr_q       <= rr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pend_q     <= pend_d;
      rf_wr_en_q <= rf_wr_en_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.alu_ready = alu_rdy;
  assign bus.mem_ready = mem_rdy;
  assign bus.rf_wr_en  = rf_wr_en_q;
  assign bus.rf_rd     = rf_rd_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.busy      = busy_q;
  assign bus.pending   = pend_q;
endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Bench for rf_writeback_ctrl: queue-based reference model compared every cycle, directed
// scenarios with literal expectations, then randomized producer/reservation traffic.
module tb_rf_writeback_ctrl;
  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_wb_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();
  rf_writeback_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  ent_t        q[$];
  logic [31:0] m_busy;
  bit          m_pref_mem;
  logic        m_wr_en;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  bit          ra, rm, acc_alu, acc_mem;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_busy = '0; m_pref_mem = 1'b0; m_wr_en = 1'b0; m_rd = '0; m_wd = '0;
    acc_alu = 1'b0; acc_mem = 1'b0;
  endtask

  task automatic cmp();
    bit full;
    full = (q.size() == DEPTH);
    ra = !full && (!bus.mem_valid || !m_pref_mem);
    rm = !full && (!bus.alu_valid || m_pref_mem);
    chk("alu_ready", 32'(bus.alu_ready), 32'(ra));
    chk("mem_ready", 32'(bus.mem_ready), 32'(rm));
    chk("rf_wr_en", 32'(bus.rf_wr_en), 32'(m_wr_en));
    if (m_wr_en) begin
      chk("rf_rd", 32'(bus.rf_rd), 32'(m_rd));
      chk("rf_wdata", bus.rf_wdata, m_wd);
    end
    chk("busy", bus.busy, m_busy);
    chk("pending", 32'(bus.pending), 32'(q.size()));
  endtask

  // One clock: compare at the falling edge, advance the model on the rising edge, return 1 later.
  task automatic step();
    ent_t e;
    bit both;
    @(negedge clk);
    cmp();
    acc_alu = bus.alu_valid && ra;
    acc_mem = bus.mem_valid && rm;
    both = bus.alu_valid && bus.mem_valid;
    @(posedge clk);
    if (rst_n) begin
      if (q.size() != 0) begin
        e = q.pop_front();
        m_wr_en = 1'b1; m_rd = e.rd; m_wd = e.d;
        m_busy[e.rd] = 1'b0;
      end else begin
        m_wr_en = 1'b0;
      end
      if (acc_alu && bus.alu_rd != 0) q.push_back('{bus.alu_rd, bus.alu_data});
      if (acc_mem && bus.mem_rd != 0) q.push_back('{bus.mem_rd, bus.mem_data});
      if (both && (acc_alu || acc_mem)) m_pref_mem = acc_alu;
      if (bus.rsv_valid && bus.rsv_rd != 0) m_busy[bus.rsv_rd] = 1'b1;
    end else begin
      acc_alu = 1'b0; acc_mem = 1'b0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.rsv_valid = 0; bus.rsv_rd = 0;
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  int   seq_rd[$];
  int   seq_wd[$];
  int   na, nm, max_pend;
  int   exp_rd[8] = '{1, 11, 2, 12, 3, 13, 4, 14};

  initial begin
    idle_inputs();
    m_reset();
    #2;
    chk("reset_wr_en", 32'(bus.rf_wr_en), 32'd0);
    chk("reset_busy", bus.busy, 32'd0);
    chk("reset_pending", 32'(bus.pending), 32'd0);
    chk("reset_rf_wdata", bus.rf_wdata, 32'd0);
    do_reset();

    // Single ALU write to x5
    bus.rsv_valid = 1; bus.rsv_rd = 5;
    step();
    bus.rsv_valid = 0;
    bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'hDEADBEEF;
    step();
    chk("single_acc", 32'(acc_alu), 32'd1);
    chk("single_busy_held", bus.busy, 32'h20);
    bus.alu_valid = 0;
    step();
    chk("single_wr_en", 32'(bus.rf_wr_en), 32'd1);
    chk("single_rd", 32'(bus.rf_rd), 32'd5);
    chk("single_data", bus.rf_wdata, 32'hDEADBEEF);
    chk("single_busy_clr", bus.busy, 32'h0);
    step();
    chk("single_one_pulse", 32'(bus.rf_wr_en), 32'd0);

    // Contention: alternating grants from ALU-preferred start
    do_reset();
    seq_rd.delete(); seq_wd.delete();
    na = 1; nm = 1; max_pend = 0;
    bus.alu_valid = 1; bus.alu_rd = 1;  bus.alu_data = 32'h11;
    bus.mem_valid = 1; bus.mem_rd = 11; bus.mem_data = 32'h21;
    for (int c = 0; c < 40 && seq_rd.size() < 8; c++) begin
      step();
      if (bus.rf_wr_en) seq_rd.push_back(int'(bus.rf_rd));
      if (acc_alu) begin
        na++;
        if (na > 4) bus.alu_valid = 0;
        else begin bus.alu_rd = 5'(na); bus.alu_data = 32'(32'h10 + na); end
      end
      if (acc_mem) begin
        nm++;
        if (nm > 4) bus.mem_valid = 0;
        else begin bus.mem_rd = 5'(10 + nm); bus.mem_data = 32'(32'h20 + nm); end
      end
    end
    chk("contention_count", 32'(seq_rd.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("contention_rd%0d", i), (i < seq_rd.size()) ? 32'(seq_rd[i]) : 32'hFFFF, 32'(exp_rd[i]));

    // Back-pressure pattern: both producers saturating, data 0xA0..0xA7
    do_reset();
    seq_wd.delete();
    na = 0; nm = 1; max_pend = 0;
    bus.alu_valid = 1; bus.alu_rd = 1; bus.alu_data = 32'hA0;
    bus.mem_valid = 1; bus.mem_rd = 2; bus.mem_data = 32'hA1;
    for (int c = 0; c < 40 && seq_wd.size() < 8; c++) begin
      step();
      if (int'(bus.pending) > max_pend) max_pend = int'(bus.pending);
      if (bus.rf_wr_en) seq_wd.push_back(int'(bus.rf_wdata));
      if (acc_alu) begin
        na += 2;
        if (na > 6) bus.alu_valid = 0;
        else begin bus.alu_rd = 5'(na + 1); bus.alu_data = 32'(32'hA0 + na); end
      end
      if (acc_mem) begin
        nm += 2;
        if (nm > 7) bus.mem_valid = 0;
        else begin bus.mem_rd = 5'(nm + 1); bus.mem_data = 32'(32'hA0 + nm); end
      end
    end
    chk("bp_max_pending", 32'(max_pend), 32'd1);
    chk("bp_count", 32'(seq_wd.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("bp_data%0d", i), (i < seq_wd.size()) ? 32'(seq_wd[i]) : 32'hFFFF, 32'(32'hA0 + i));

    // x0 drop
    do_reset();
    bus.mem_valid = 1; bus.mem_rd = 0; bus.mem_data = 32'hFFFFFFFF;
    #1 chk("x0_ready", 32'(bus.mem_ready), 32'd1);
    step();
    bus.mem_valid = 0;
    for (int c = 0; c < 3; c++) begin
      chk("x0_pending", 32'(bus.pending), 32'd0);
      chk("x0_wr_en", 32'(bus.rf_wr_en), 32'd0);
      chk("x0_busy", bus.busy, 32'd0);
      step();
    end

    // Scoreboard collision on x7
    do_reset();
    bus.rsv_valid = 1; bus.rsv_rd = 7;
    step();
    bus.rsv_valid = 0;
    bus.alu_valid = 1; bus.alu_rd = 7; bus.alu_data = 32'h77;
    step();
    bus.alu_valid = 0;
    bus.rsv_valid = 1; bus.rsv_rd = 7;
    step();
    chk("coll_wr_en", 32'(bus.rf_wr_en), 32'd1);
    chk("coll_busy_set_wins", bus.busy, 32'h80);
    bus.rsv_valid = 0;
    bus.alu_valid = 1; bus.alu_rd = 7; bus.alu_data = 32'h78;
    step();
    bus.alu_valid = 0;
    step();
    chk("coll_second_data", bus.rf_wdata, 32'h78);
    chk("coll_busy_clr", bus.busy, 32'h0);

    // Async reset mid-cycle with a buffered write and busy=0xA0
    do_reset();
    bus.rsv_valid = 1; bus.rsv_rd = 5;
    step();
    bus.rsv_rd = 7;
    step();
    bus.rsv_valid = 0;
    bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'h55;
    step();
    bus.alu_valid = 0;
    chk("ar_pre_busy", bus.busy, 32'hA0);
    chk("ar_pre_pending", 32'(bus.pending), 32'd1);
    #2 rst_n = 0;
    m_reset();
    #1;
    chk("ar_wr_en", 32'(bus.rf_wr_en), 32'd0);
    chk("ar_busy", bus.busy, 32'd0);
    chk("ar_pending", 32'(bus.pending), 32'd0);
    chk("ar_rf_rd", 32'(bus.rf_rd), 32'd0);
    step();
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("ar_no_write", 32'(bus.rf_wr_en), 32'd0);
    end

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (!bus.alu_valid || acc_alu) begin
        bus.alu_valid = ($urandom_range(0, 3) != 0);
        bus.alu_rd = 5'($urandom_range(0, 31));
        bus.alu_data = $urandom;
      end
      if (!bus.mem_valid || acc_mem) begin
        bus.mem_valid = ($urandom_range(0, 2) == 0);
        bus.mem_rd = 5'($urandom_range(0, 31));
        bus.mem_data = $urandom;
      end
      bus.rsv_valid = ($urandom_range(0, 1) == 1);
      bus.rsv_rd = 5'($urandom_range(0, 31));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
